pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
Parametrised, pipelined ripple-carry adder/subtractor. It is the multi-bit successor of the single-bit full adder cell. The WIDTH-bit operation is split into STAGES equal slices, and carry propagates one slice per clock, so the block meets timing at wide widths. A valid/ready handshake on both sides allows back-pressure. The block sits in datapaths between registered producers and consumers.

Parameters:
WIDTH, 16, operand and sum width in bits; must be ≥1.
STAGES, 4, number of pipeline slices; WIDTH must be an integer multiple of STAGES (elaboration error otherwise). CHUNK = WIDTH/STAGES.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands and controls present this cycle.
in_ready  output  1  block accepts the operands this cycle.
a  input  WIDTH  operand A (two's complement or unsigned).
b  input  WIDTH  operand B.
cin  input  1  carry in; ignored when sub=1.
sub  input  1  0 = a+b+cin; 1 = a-b (a + ~b + 1).
out_valid  output  1  result present on s/cout/ovf.
out_ready  input  1  downstream accepts the result.
s  output  WIDTH  sum/difference, modulo 2^WIDTH.
cout  output  1  carry out of the MSB (for subtract, 1 = no borrow).
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset: all stage valid bits = 0; out_valid = 0; s = 0, cout = 0, ovf = 0. in_ready = 1 in the cycle after reset deasserts. Reset mid-operation discards all in-flight results; no partial result ever appears.
- Transfer: input is accepted when in_valid && in_ready. Output is consumed when out_valid && out_ready.
- Advance condition: adv = !out_valid || out_ready. in_ready = adv, combinational.
- Pipeline moves: when adv=1, every stage shifts one position. When adv=0, all stage registers hold, and a, b, cin, sub are ignored.
- Stage k (0..STAGES-1):
  - Adds slice k of a and the effective b (b, or ~b when sub=1), plus the carry from stage k-1.
  - Stage 0's carry input is cin when sub=0, and 1 when sub=1.
  - Each stage registers its CHUNK sum bits and its carry out.
  - Upper operand slices not yet consumed are carried forward in skew registers alongside the partial result.
- Latency: exactly STAGES cycles from acceptance to out_valid, with no stall.
- Throughput: one operation per cycle while out_ready=1. No bubbles are inserted. Gaps in in_valid propagate as gaps in out_valid.
- Output stability: s, cout and ovf are registered, and hold stable while out_valid=1 && out_ready=0.
- Stage-0 bubbles: when in_valid=0 and adv=1, stage 0 loads valid=0. Data bits are don't-care but must not X-propagate into ovf/cout while valid=1.
- ovf: computed in the last stage from the MSB slice's internal carry-in and carry-out.
- Ordering: results emerge strictly in acceptance order. No reordering and no dropping.
- STAGES=1: degenerates to a single-register adder with latency 1.

Test Plan:
1. WIDTH=16, STAGES=4: a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 → exactly 4 cycles later out_valid=1, s=0x0000, cout=1, ovf=0.
2. Signed overflow and subtract:
   - a=0x7FFF, b=0x0001, sub=0 → s=0x8000, cout=0, ovf=1.
   - Next cycle, a=0x0005, b=0x0007, sub=1, cin=1 (ignored) → s=0xFFFE, cout=0, ovf=0.
   - Both results appear on consecutive cycles.
3. Back-to-back: 8 random operand pairs on consecutive cycles with out_ready=1 → 8 consecutive out_valid cycles, each matching a golden model (a+b+cin or a-b) mod 2^16.
4. Back-pressure:
   - Stream 6 ops; hold out_ready=0 for 3 cycles once out_valid rises.
   - Required: in_ready=0 during the hold; s/cout/ovf unchanged during the hold; no loss or duplication; order preserved.
5. Reset mid-flight: accept 3 ops, assert rst for 1 cycle → out_valid=0, s=0 the cycle after; none of the 3 results ever appear; a new op after reset returns correctly after 4 cycles.
6. STAGES=1, WIDTH=8: a=0x80, b=0x80, sub=0 → 1-cycle latency, s=0x00, cout=1, ovf=1. Separately, WIDTH=12, STAGES=5 must fail elaboration.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: the WIDTH-bit add is cut into STAGES
// slices of CHUNK bits, with one slice resolved per clock and a valid/ready handshake.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = (STAGES > 0) ? WIDTH / STAGES : 1;

  if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH (%0d) must be >= 1 and a multiple of STAGES (%0d)",
           WIDTH, STAGES);
  end

  // CHUNK-bit add; bit CHUNK of the result is the slice carry out.
  function automatic logic [CHUNK:0] slice_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             c);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
  endfunction

  // Carry into the MSB is recovered as x ^ y ^ sum at the MSB position.
  function automatic logic signed_ovf(input logic x_msb, input logic y_msb,
                                      input logic s_msb, input logic c_out);
    return x_msb ^ y_msb ^ s_msb ^ c_out;
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM = WIDTH - k * CHUNK;

    logic [REM-1:0]         a_in;
    logic [REM-1:0]         b_in;
    logic                   c_in;
    logic                   vld_in;
    logic [CHUNK:0]         add;
    logic [(k+1)*CHUNK-1:0] sum_d;
    logic [(k+1)*CHUNK-1:0] sum_p;
    logic                   carry_p;
    logic                   vld_p;

    assign add = slice_add(a_in[CHUNK-1:0], b_in[CHUNK-1:0], c_in);

    if (k == 0) begin : g_head
      assign a_in   = a;
      assign b_in   = sub ? ~b : b;
      assign c_in   = sub | cin;
      assign vld_in = in_valid;
      assign sum_d  = add[CHUNK-1:0];
    end else begin : g_link
      assign a_in   = g_stage[k-1].g_fwd.a_p;
      assign b_in   = g_stage[k-1].g_fwd.b_p;
      assign c_in   = g_stage[k-1].carry_p;
      assign vld_in = g_stage[k-1].vld_p;
      assign sum_d  = {add[CHUNK-1:0], g_stage[k-1].sum_p};
    end

    // ---- stage k register boundary ----
    always_ff @(posedge clk) begin
      if (rst)      vld_p <= 1'b0;
      else if (adv) vld_p <= vld_in;
    end

    if (k == STAGES - 1) begin : g_tail
      logic ovf_p;
      always_ff @(posedge clk) begin
        if (rst) begin
          sum_p   <= '0;
          carry_p <= 1'b0;
          ovf_p   <= 1'b0;
        end else if (adv) begin
          sum_p   <= sum_d;
          carry_p <= add[CHUNK];
          ovf_p   <= signed_ovf(a_in[CHUNK-1], b_in[CHUNK-1], add[CHUNK-1], add[CHUNK]);
        end
      end
    end else begin : g_fwd
      // Skew registers: only the operand slices later stages still need.
      logic [REM-CHUNK-1:0] a_p;
      logic [REM-CHUNK-1:0] b_p;
      always_ff @(posedge clk) begin
        if (adv) begin
          sum_p   <= sum_d;
          carry_p <= add[CHUNK];
          a_p     <= a_in[REM-1:CHUNK];
          b_p     <= b_in[REM-1:CHUNK];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_p;
  assign s         = g_stage[STAGES-1].sum_p;
  assign cout      = g_stage[STAGES-1].carry_p;
  assign ovf       = g_stage[STAGES-1].g_tail.ovf_p;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (16-bit/4-stage) plus an 8-bit/1-stage instance.
module tb_pipelined_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  logic         in_valid8 = 1'b0;
  logic         in_ready8;
  logic [7:0]   a8 = '0;
  logic [7:0]   b8 = '0;
  logic         out_valid8;
  logic [7:0]   s8;
  logic         cout8;
  logic         ovf8;

  pipelined_adder #(.WIDTH(W), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(1'b0), .sub(1'b0),
    .out_valid(out_valid8), .out_ready(1'b1),
    .s(s8), .cout(cout8), .ovf(ovf8)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_push  = 0;
  int n_pop   = 0;

  typedef struct packed {
    logic         cout;
    logic         ovf;
    logic [W-1:0] s;
  } result_t;

  result_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Independent golden model: wide add, overflow from operand/result signs.
  function automatic result_t golden(input logic [W-1:0] ga, input logic [W-1:0] gb,
                                     input logic gc, input logic gs);
    result_t      r;
    logic [W:0]   full;
    logic [W-1:0] be;
    be   = gs ? ~gb : gb;
    full = {1'b0, ga} + {1'b0, be} + {{W{1'b0}}, (gs ? 1'b1 : gc)};
    r.s    = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (ga[W-1] == be[W-1]) && (r.s[W-1] != ga[W-1]);
    return r;
  endfunction

  // Scoreboard: push on accepted input, pop/compare on consumed output.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready) begin
      n_pop++;
      if (sb_q.size() == 0) check("sb_unexpected", 32'd1, 32'd0);
      else begin
        result_t e;
        e = sb_q.pop_front();
        check("sb_result", {14'd0, cout, ovf, s}, {14'd0, e.cout, e.ovf, e.s});
      end
    end
    if (rst) sb_q.delete();
    else if (in_valid && in_ready) begin
      sb_q.push_back(golden(a, b, cin, sub));
      n_push++;
    end
  end

  task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                       input logic ts);
    int   n   = 0;
    logic acc = 1'b0;
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) check("drive_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (out_valid !== 1'b1) check(tag, 32'd0, 32'd1);
  endtask

  initial begin
    result_t cap;
    int      drops;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_outputs", {14'd0, cout, ovf, s}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Test 1: carry ripples through all slices, latency of exactly 4
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("t1_latency_c%0d", i), {31'd0, out_valid}, (i == 4) ? 32'd1 : 32'd0);
    end
    check("t1_result", {14'd0, cout, ovf, s}, {14'd0, 1'b1, 1'b0, 16'h0000});
    @(posedge clk); #1;

    // Test 2: signed overflow then subtract on the next cycle
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    drive(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_out("t2_timeout");
    check("t2_ovf_result", {14'd0, cout, ovf, s}, {14'd0, 1'b0, 1'b1, 16'h8000});
    @(negedge clk);
    check("t2_sub_valid", {31'd0, out_valid}, 32'd1);
    check("t2_sub_result", {14'd0, cout, ovf, s}, {14'd0, 1'b0, 1'b0, 16'hFFFE});
    repeat (3) @(posedge clk); #1;

    // Test 3: 8 back-to-back random ops give 8 consecutive results
    fork
      for (int i = 0; i < 8; i++)
        drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      begin
        wait_out("t3_timeout");
        for (int i = 1; i < 8; i++) begin
          @(negedge clk);
          check($sformatf("t3_run_%0d", i), {31'd0, out_valid}, 32'd1);
        end
        @(negedge clk);
        check("t3_run_end", {31'd0, out_valid}, 32'd0);
      end
    join
    repeat (3) @(posedge clk); #1;

    // Test 4: back-pressure while streaming 6 ops
    fork
      for (int i = 0; i < 6; i++)
        drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      begin
        wait_out("t4_timeout");
        @(posedge clk); #1;
        out_ready = 1'b0;
        cap = {cout, ovf, s};
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("t4_in_ready_hold", {31'd0, in_ready}, 32'd0);
          check("t4_valid_hold", {31'd0, out_valid}, 32'd1);
          check("t4_data_hold", {14'd0, cout, ovf, s}, {14'd0, cap});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk); #1;
    check("t4_drained", sb_q.size(), 32'd0);
    check("t4_no_loss", n_pop, n_push);

    // Test 5: reset with 3 ops in flight
    drops = n_pop;
    for (int i = 0; i < 3; i++) drive(16'h1111 * (i + 1), 16'h0101, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rst_s", {16'd0, s}, 32'd0);
    repeat (6) @(negedge clk);
    check("t5_no_stale", n_pop, drops);
    @(posedge clk); #1;
    drive(16'h1234, 16'h4321, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("t5_latency_c%0d", i), {31'd0, out_valid}, (i == 4) ? 32'd1 : 32'd0);
    end
    check("t5_result", {16'd0, s}, 32'h5556);

    // Test 6: single-stage 8-bit instance, latency 1
    @(posedge clk); #1;
    a8 = 8'h80; b8 = 8'h80; in_valid8 = 1'b1;
    @(negedge clk);
    check("t6_in_ready", {31'd0, in_ready8}, 32'd1);
    check("t6_pre_valid", {31'd0, out_valid8}, 32'd0);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    check("t6_valid", {31'd0, out_valid8}, 32'd1);
    check("t6_result", {22'd0, cout8, ovf8, s8}, {22'd0, 1'b1, 1'b1, 8'h00});
    @(negedge clk);
    check("t6_bubble", {31'd0, out_valid8}, 32'd0);

    repeat (2) @(posedge clk);
    check("final_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
